// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Instruction-side responder for the 8-bit CPU. Holds a 2**ADDR_W x DATA_W
//   instruction RAM filled through a byte-wide valid/ready load port. It
//   answers the CPU's PC combinationally. It also sequences the CPU's life:
//   the CPU is held in reset while loading, released to run, and halted at
//   program end.
//
//   Optional feature macro: LOAD_CHECKSUM_EN adds load_sum, which is the
//   running sum (mod 2**DATA_W) of the accepted load beats.
//
// Ports
//   clk          in   single clock, all state on rising edge
//   RST          in   synchronous active-high reset
//   load_start   in   pulse: enter LOAD, clear write pointer
//   load_valid   in   load beat valid
//   load_data    in   load beat byte
//   load_ready   out  RAM can accept a beat (LOAD and not full)
//   load_done    in   pulse: close program, start CPU
//   run_start    in   pulse: rerun stored program from IDLE/HALT
//   pc_in        in   CPU program counter
//   instruction  out  mem[pc_in] while running inside the program, else NOP_INSTR
//   cpu_rst      out  registered reset to CPU, low only in RUN
//   prog_len     out  bytes in stored program, 0..2**ADDR_W
//   halted       out  registered, high in HALT
//   state        out  IDLE=0, LOAD=1, RUN=2, HALT=3
//   load_sum     out  (LOAD_CHECKSUM_EN only) checksum of accepted beats
module instr_mem_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 8,
  parameter logic [7:0]  NOP_INSTR = 8'h00
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_done,
  input  logic              run_start,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   prog_len,
  output logic              halted,
`ifdef LOAD_CHECKSUM_EN
  output logic [DATA_W-1:0] load_sum,
`endif
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  // The write pointer doubles as the program length. After every accepted
  // beat, prog_len equals wr_ptr + 1, which is the new wr_ptr. Both are
  // cleared together. The MSB set means 2**ADDR_W bytes are held (full).
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              cpu_rst_q, halted_q;
  logic              accept;
  logic              in_prog;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign load_ready = (state_q == S_LOAD) && !wr_ptr_q[ADDR_W];
  // A restart in the same cycle wins over a beat, so that beat is dropped.
  assign accept     = load_ready && load_valid && !load_start;

  // The compare is ADDR_W+1 bits wide. A PC that wraps can never fall
  // outside a full program, and prog_len=0 never matches.
  assign in_prog     = ({1'b0, pc_in} < wr_ptr_q);
  assign instruction = (state_q == S_RUN && in_prog) ? mem[pc_in] : NOP_INSTR[DATA_W-1:0];

  assign prog_len = wr_ptr_q;
  assign cpu_rst  = cpu_rst_q;
  assign halted   = halted_q;
  assign state    = state_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (load_start)     state_d = S_LOAD;
        else if (run_start) state_d = S_RUN;
      end
      S_LOAD: begin
        if (load_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (!in_prog) state_d = S_HALT;
      end
      S_HALT: begin
        if (run_start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    // load_start outranks load_done and run_start from any state.
    if (load_start) begin
      state_d  = S_LOAD;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      cpu_rst_q <= 1'b1;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      // These are registered from the next state, so cpu_rst drops in the
      // first cycle that state shows RUN.
      cpu_rst_q <= (state_d != S_RUN);
      halted_q  <= (state_d == S_HALT);
    end
  end

  // The RAM is not reset. A cleared prog_len makes its contents invalid.
  always_ff @(posedge clk) begin
    if (!RST && accept) mem[wr_ptr_q[ADDR_W-1:0]] <= load_data;
  end

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load_start)  sum_d = '0;
    else if (accept) sum_d = sum_q + load_data;
  end

  always_ff @(posedge clk) begin
    if (RST) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign load_sum = sum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
  logic       clk = 1'b0;
  logic       RST, load_start, load_valid, load_ready, load_done, run_start;
  logic [7:0] load_data, pc_in, instruction;
  logic       cpu_rst, halted;
  logic [8:0] prog_len;
  logic [1:0] state;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] load_sum;
  logic [7:0] exp_sum;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  instr_mem_loader dut (
    .clk(clk), .RST(RST), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .run_start(run_start), .pc_in(pc_in), .instruction(instruction),
    .cpu_rst(cpu_rst), .prog_len(prog_len), .halted(halted),
`ifdef LOAD_CHECKSUM_EN
    .load_sum(load_sum),
`endif
    .state(state)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  initial begin
    RST = 1; load_start = 0; load_valid = 0; load_data = 0;
    load_done = 0; run_start = 0; pc_in = 0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_prog_len", 32'(prog_len), 0);
    chk("rst_ready", 32'(load_ready), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_instr", 32'(instruction), 32'h00);
    RST = 0;

    // A load_done in IDLE is ignored.
    load_done = 1; tick(); load_done = 0;
    chk("idle_done_ign", 32'(state), 0);

    // Test 1: load three bytes and run.
    load_start = 1; tick(); load_start = 0;
    chk("t1_state_load", 32'(state), 1);
    chk("t1_ready", 32'(load_ready), 1);
    chk("t1_cpu_rst_load", 32'(cpu_rst), 1);
    load_valid = 1;
    load_data = 8'h12; tick();
    load_data = 8'h34; tick();
    load_data = 8'h56; tick();
    load_valid = 0;
    chk("t1_prog_len", 32'(prog_len), 3);
`ifdef LOAD_CHECKSUM_EN
    chk("t1_sum", 32'(load_sum), 32'h9C);
`endif
    load_done = 1; tick(); load_done = 0;
    chk("t1_state_run", 32'(state), 2);
    chk("t1_cpu_rst_run", 32'(cpu_rst), 0);
    pc_in = 1; #1 chk("t1_instr_pc1", 32'(instruction), 32'h34);
    pc_in = 0; #1 chk("t1_instr_pc0", 32'(instruction), 32'h12);
    pc_in = 2; #1 chk("t1_instr_pc2", 32'(instruction), 32'h56);

    // Test 2: the PC runs past the program end.
    pc_in = 3; #1 chk("t2_instr_past", 32'(instruction), 32'h00);
    tick();
    chk("t2_state_halt", 32'(state), 3);
    chk("t2_halted", 32'(halted), 1);
    chk("t2_cpu_rst", 32'(cpu_rst), 1);
    chk("t2_instr", 32'(instruction), 32'h00);

    // Test 6: in HALT, load_start wins over run_start.
    load_start = 1; run_start = 1; tick(); load_start = 0; run_start = 0;
    chk("t6_state", 32'(state), 1);
    chk("t6_prog_len", 32'(prog_len), 0);
    chk("t6_halted", 32'(halted), 0);

    // Test 3: 257 continuous beats. Only 256 are accepted.
`ifdef LOAD_CHECKSUM_EN
    exp_sum = 8'h00;
    for (int i = 0; i < 256; i++) exp_sum = exp_sum + pat(i);
`endif
    load_valid = 1;
    for (int i = 0; i < 257; i++) begin
      load_data = pat(i);
      if (i == 0)   chk("t3_ready_first", 32'(load_ready), 1);
      if (i == 255) chk("t3_ready_last", 32'(load_ready), 1);
      if (i == 256) chk("t3_ready_full", 32'(load_ready), 0);
      tick();
    end
    load_valid = 0;
    chk("t3_prog_len", 32'(prog_len), 256);
    chk("t3_ready_after", 32'(load_ready), 0);
`ifdef LOAD_CHECKSUM_EN
    chk("t3_sum", 32'(load_sum), 32'(exp_sum));
`endif
    pc_in = 8'd255;
    load_done = 1; tick(); load_done = 0;
    chk("t3_state_run", 32'(state), 2);
    chk("t3_mem255", 32'(instruction), 32'(pat(255)));
    pc_in = 0;   #1 chk("t3_mem0", 32'(instruction), 32'(pat(0)));
    pc_in = 100; #1 chk("t3_mem100", 32'(instruction), 32'(pat(100)));
    run_start = 1; pc_in = 8'd255; tick(); run_start = 0;
    chk("t3_still_run", 32'(state), 2);

    // Test 4: a load_start while running puts the CPU back in reset.
    // An empty program then gives one RUN cycle followed by HALT.
    load_start = 1; tick(); load_start = 0;
    chk("t4_state_load", 32'(state), 1);
    chk("t4_cpu_rst", 32'(cpu_rst), 1);
    load_done = 1; tick(); load_done = 0;
    chk("t4_state_run", 32'(state), 2);
    chk("t4_instr_nop", 32'(instruction), 32'h00);
    tick();
    chk("t4_state_halt", 32'(state), 3);

    // Test 5: a reset after two accepted beats discards them.
    load_start = 1; tick(); load_start = 0;
    load_valid = 1; load_data = 8'hAA; tick(); load_data = 8'hBB; tick();
    load_valid = 0;
    chk("t5_prog_len_2", 32'(prog_len), 2);
    RST = 1; tick(); RST = 0;
    chk("t5_state_idle", 32'(state), 0);
    chk("t5_prog_len", 32'(prog_len), 0);
    chk("t5_ready", 32'(load_ready), 0);
`ifdef LOAD_CHECKSUM_EN
    chk("t5_sum", 32'(load_sum), 0);
`endif
    run_start = 1; tick(); run_start = 0;
    chk("t5_state_run", 32'(state), 2);
    chk("t5_cpu_rst", 32'(cpu_rst), 0);
    tick();
    chk("t5_state_halt", 32'(state), 3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
